// File: rtl/gray_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// The Gray conversions work on any pointer width up to 32 bits (zero-extended).
package gray_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int PTR_W          = DEFAULT_ADDR_W + 1;
  localparam int DEPTH          = 2 ** DEFAULT_ADDR_W;

  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_counter.sv
// Binary + registered Gray pointer pair with wrap-around increment.
// Shared by the write-side and read-side FIFO controllers.
module gray_ptr_counter
  import gray_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr_bin,
  output logic [W-1:0] ptr_gray,
  output logic [W-1:0] ptr_bin_next
);

  logic [W-1:0] gray_next;

  always_comb begin
    ptr_bin_next = ptr_bin + W'(inc);
    gray_next    = W'(bin2gray(32'(ptr_bin_next)));
  end

  // Gray is registered so the read-domain synchroniser only ever sees one-bit steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
    end else begin
      ptr_bin  <= ptr_bin_next;
      ptr_gray <= gray_next;
    end
  end

endmodule

// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: handshake, write pointer,
// and occupancy flags derived from the synchronised Gray read pointer.
module gray_fifo_wr_ctrl
  import gray_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  input  logic [ADDR_W:0]   rd_ptr_gray_sync,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              err
);

  localparam int PW         = ADDR_W + 1;
  localparam int FIFO_DEPTH = 2 ** ADDR_W;

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] wnext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_next;

  assign in_ready = !full && !rst;
  assign wr_en    = in_valid && in_ready;
  assign wr_addr  = wptr_bin[ADDR_W-1:0];

  gray_ptr_counter #(
    .W (PW)
  ) u_wptr (
    .clk          (clk),
    .rst          (rst),
    .inc          (wr_en),
    .ptr_bin      (wptr_bin),
    .ptr_gray     (wr_ptr_gray),
    .ptr_bin_next (wnext)
  );

  // Modular difference: a wrapped read pointer still yields the right occupancy.
  always_comb begin
    rbin     = PW'(gray2bin(32'(rd_ptr_gray_sync)));
    lvl_next = wnext - rbin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      err         <= 1'b0;
    end else begin
      level       <= lvl_next;
      full        <= (lvl_next == PW'(FIFO_DEPTH));
      almost_full <= (lvl_next >= PW'(AFULL_THRESH));
      err         <= err || (lvl_next > PW'(FIFO_DEPTH));
    end
  end

endmodule
